// File: rtl/liteeth_1rw1r_masked_sram.sv
// liteeth_1rw1r_masked_sram: 1RW+1R byte-masked SRAM with post-reset clear, read-first rw0 and optional r0 forwarding.
// Define SRAM_PARITY_EN to add per-byte even parity storage and r0_perr/rw0_perr outputs.
module liteeth_1rw1r_masked_sram #(
    parameter int              BITS       = 64,
    parameter int              WORD_DEPTH = 1024,
    parameter int              ADDR_WIDTH = $clog2(WORD_DEPTH),
    parameter int              RD_LAT     = 1,
    parameter int              R0_FWD     = 1,
    parameter logic [BITS-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic                  r0_ce_in,
    input  logic [ADDR_WIDTH-1:0] r0_addr_in,
    output logic [BITS-1:0]       r0_rd_out,
    output logic                  r0_rd_valid,
    input  logic                  rw0_ce_in,
    input  logic                  rw0_we_in,
    input  logic [BITS/8-1:0]     rw0_wmask_in,
    input  logic [ADDR_WIDTH-1:0] rw0_addr_in,
    input  logic [BITS-1:0]       rw0_wd_in,
    output logic [BITS-1:0]       rw0_rd_out,
    output logic                  rw0_rd_valid,
`ifdef SRAM_PARITY_EN
    output logic [BITS/8-1:0]     r0_perr,
    output logic [BITS/8-1:0]     rw0_perr,
`endif
    output logic                  addr_err
);
    localparam int                    NB       = BITS / 8;
    localparam int                    LAST_I   = WORD_DEPTH - 1;
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = WORD_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = LAST_I[ADDR_WIDTH-1:0];

    typedef enum logic {INIT, READY} state_t;
    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic                  r_init_done, r_addr_err;
    logic [BITS-1:0]       r_mem [WORD_DEPTH];
    logic [BITS-1:0]       w_bmask, w_r0_old, w_rw_old, w_rw_new, w_r0_data;
    logic                  w_ready, w_r0_acc, w_rw_acc, w_r0_oor, w_rw_oor, w_wr, w_coll;
    logic                  r_r0_v1, r_rw_v1;
    logic [BITS-1:0]       r_r0_d1, r_rw_d1;

    for (genvar i = 0; i < NB; i++) begin : g_mask
        assign w_bmask[8*i +: 8] = {8{rw0_wmask_in[i]}};
    end

    assign w_ready   = r_state == READY;
    assign w_r0_acc  = w_ready & r0_ce_in;
    assign w_rw_acc  = w_ready & rw0_ce_in;
    assign w_r0_oor  = {1'b0, r0_addr_in} >= LP_DEPTH;
    assign w_rw_oor  = {1'b0, rw0_addr_in} >= LP_DEPTH;
    assign w_wr      = w_rw_acc & rw0_we_in & ~w_rw_oor;
    assign w_r0_old  = w_r0_oor ? '0 : r_mem[r0_addr_in];
    assign w_rw_old  = w_rw_oor ? '0 : r_mem[rw0_addr_in];
    assign w_rw_new  = (w_rw_old & ~w_bmask) | (rw0_wd_in & w_bmask);
    // an in-range write at the same address implies r0 is in range too
    assign w_coll    = (R0_FWD != 0) & w_wr & (r0_addr_in == rw0_addr_in);
    assign w_r0_data = w_coll ? w_rw_new : w_r0_old;

    always_comb begin
        w_state_nxt = (r_state == INIT && r_init_addr == LP_LAST) ? READY : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_init_addr <= '0;
            r_init_done <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_addr <= w_ready ? r_init_addr : r_init_addr + 1'b1;
            r_init_done <= w_ready;
            r_addr_err  <= r_addr_err | (w_r0_acc & w_r0_oor) | (w_rw_acc & w_rw_oor);
        end
    end

    always_ff @(posedge clk) begin
        if (!w_ready) r_mem[r_init_addr] <= INIT_VALUE;
        else if (w_wr) r_mem[rw0_addr_in] <= w_rw_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r0_v1 <= 1'b0;
            r_rw_v1 <= 1'b0;
            r_r0_d1 <= '0;
            r_rw_d1 <= '0;
        end else begin
            r_r0_v1 <= w_r0_acc;
            r_rw_v1 <= w_rw_acc;
            if (w_r0_acc) r_r0_d1 <= w_r0_data;
            if (w_rw_acc) r_rw_d1 <= w_rw_old;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic            r_r0_v2, r_rw_v2;
        logic [BITS-1:0] r_r0_d2, r_rw_d2;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_r0_v2 <= 1'b0;
                r_rw_v2 <= 1'b0;
                r_r0_d2 <= '0;
                r_rw_d2 <= '0;
            end else begin
                r_r0_v2 <= r_r0_v1;
                r_rw_v2 <= r_rw_v1;
                if (r_r0_v1) r_r0_d2 <= r_r0_d1;
                if (r_rw_v1) r_rw_d2 <= r_rw_d1;
            end
        end
        assign r0_rd_out    = r_r0_d2;
        assign r0_rd_valid  = r_r0_v2;
        assign rw0_rd_out   = r_rw_d2;
        assign rw0_rd_valid = r_rw_v2;
    end else begin : g_lat1
        assign r0_rd_out    = r_r0_d1;
        assign r0_rd_valid  = r_r0_v1;
        assign rw0_rd_out   = r_rw_d1;
        assign rw0_rd_valid = r_rw_v1;
    end

    assign init_done = r_init_done;
    assign addr_err  = r_addr_err;

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] r_par [WORD_DEPTH];
    logic [NB-1:0] w_wpar, w_ipar, w_r0_perr, w_rw_perr, r_r0_pe1, r_rw_pe1;

    // forwarded bytes carry freshly written data, so they cannot report a stored error
    for (genvar i = 0; i < NB; i++) begin : g_par
        assign w_wpar[i]    = ^rw0_wd_in[8*i +: 8];
        assign w_ipar[i]    = ^INIT_VALUE[8*i +: 8];
        assign w_r0_perr[i] = ~w_r0_oor & ~(w_coll & rw0_wmask_in[i]) & (^r_mem[r0_addr_in][8*i +: 8] ^ r_par[r0_addr_in][i]);
        assign w_rw_perr[i] = ~w_rw_oor & (^r_mem[rw0_addr_in][8*i +: 8] ^ r_par[rw0_addr_in][i]);
    end

    always_ff @(posedge clk) begin
        if (!w_ready) r_par[r_init_addr] <= w_ipar;
        else if (w_wr) r_par[rw0_addr_in] <= (r_par[rw0_addr_in] & ~rw0_wmask_in) | (w_wpar & rw0_wmask_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r0_pe1 <= '0;
            r_rw_pe1 <= '0;
        end else begin
            if (w_r0_acc) r_r0_pe1 <= w_r0_perr;
            if (w_rw_acc) r_rw_pe1 <= w_rw_perr;
        end
    end

    if (RD_LAT == 2) begin : g_pe2
        logic [NB-1:0] r_r0_pe2, r_rw_pe2;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_r0_pe2 <= '0;
                r_rw_pe2 <= '0;
            end else begin
                if (r_r0_v1) r_r0_pe2 <= r_r0_pe1;
                if (r_rw_v1) r_rw_pe2 <= r_rw_pe1;
            end
        end
        assign r0_perr  = r_r0_pe2;
        assign rw0_perr = r_rw_pe2;
    end else begin : g_pe1
        assign r0_perr  = r_r0_pe1;
        assign rw0_perr = r_rw_pe1;
    end

    task automatic flip_bit(input logic [ADDR_WIDTH-1:0] a, input int b);
        r_mem[a][b] = ~r_mem[a][b];
    endtask
`endif
endmodule

// File: tb/tb_liteeth_1rw1r_masked_sram.sv
// tb_liteeth_1rw1r_masked_sram: directed bench for two instances sharing one stimulus:
// u_a uses defaults, u_b is 1000 deep, two-cycle latency, no r0 forwarding, nonzero init word.
module tb_liteeth_1rw1r_masked_sram;
    localparam logic [63:0] B_INIT = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] D5     = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] D9     = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] MIX    = 64'h1122_3344_AAAA_AAAA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_ce = 1'b0, rw_ce = 1'b0, rw_we = 1'b0;
    logic [9:0]  r0_addr = '0, rw_addr = '0;
    logic [7:0]  rw_mask = '0;
    logic [63:0] rw_wd = '0;
    logic        a_done, a_r0v, a_rwv, a_err, b_done, b_r0v, b_rwv, b_err;
    logic [63:0] a_r0, a_rw, b_r0, b_rw;
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;

    liteeth_1rw1r_masked_sram u_a (
        .clk(clk), .rst_n(rst_n), .init_done(a_done),
        .r0_ce_in(r0_ce), .r0_addr_in(r0_addr), .r0_rd_out(a_r0), .r0_rd_valid(a_r0v),
        .rw0_ce_in(rw_ce), .rw0_we_in(rw_we), .rw0_wmask_in(rw_mask), .rw0_addr_in(rw_addr),
        .rw0_wd_in(rw_wd), .rw0_rd_out(a_rw), .rw0_rd_valid(a_rwv), .addr_err(a_err)
    );

    liteeth_1rw1r_masked_sram #(.WORD_DEPTH(1000), .RD_LAT(2), .R0_FWD(0), .INIT_VALUE(B_INIT)) u_b (
        .clk(clk), .rst_n(rst_n), .init_done(b_done),
        .r0_ce_in(r0_ce), .r0_addr_in(r0_addr), .r0_rd_out(b_r0), .r0_rd_valid(b_r0v),
        .rw0_ce_in(rw_ce), .rw0_we_in(rw_we), .rw0_wmask_in(rw_mask), .rw0_addr_in(rw_addr),
        .rw0_wd_in(rw_wd), .rw0_rd_out(b_rw), .rw0_rd_valid(b_rwv), .addr_err(b_err)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r0_ce = 1'b0;
        rw_ce = 1'b0;
        rw_we = 1'b0;
        rw_mask = '0;
    endtask

    // counts edges after release until each init_done rises; optional ce noise early in the clear
    task automatic wait_init(input bit noise, output int ta, output int tb, output int nv);
        ta = 0;
        tb = 0;
        nv = 0;
        for (int n = 1; n <= 1500 && (ta == 0 || tb == 0); n++) begin
            if (noise && n <= 500) begin
                r0_ce = 1'b1; r0_addr = 10'd5; rw_ce = 1'b1; rw_we = 1'b1;
                rw_mask = 8'hFF; rw_addr = 10'd5; rw_wd = ONES;
            end else idle();
            cycle();
            if (a_done && ta == 0) ta = n;
            if (b_done && tb == 0) tb = n;
            nv += int'(a_r0v) + int'(b_r0v) + int'(a_rwv) + int'(b_rwv);
        end
    endtask

    task automatic test_reset();
        int ta, tb, nv;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_r0 !== 64'h0 || a_rw !== 64'h0) begin errs++; $display("FAIL reset_data_a: got r0=%h rw=%h want 0", a_r0, a_rw); end
        checks++; if ({a_r0v, a_rwv, a_done, a_err} !== 4'b0) begin errs++; $display("FAIL reset_flags_a: got %b want 0000", {a_r0v, a_rwv, a_done, a_err}); end
        checks++; if ({b_r0v, b_rwv, b_done, b_err} !== 4'b0 || b_r0 !== 64'h0) begin errs++; $display("FAIL reset_b: got flags=%b r0=%h want 0", {b_r0v, b_rwv, b_done, b_err}, b_r0); end
        rst_n = 1'b1;
        wait_init(1'b1, ta, tb, nv);
        checks++; if (ta != 1025) begin errs++; $display("FAIL init_time_a: got %0d want 1025", ta); end
        checks++; if (tb != 1001) begin errs++; $display("FAIL init_time_b: got %0d want 1001", tb); end
        checks++; if (nv != 0) begin errs++; $display("FAIL init_ce_ignored: got %0d valids want 0", nv); end
    endtask

    task automatic test_init_read();
        idle(); r0_ce = 1'b1; r0_addr = 10'd5; rw_ce = 1'b1; rw_addr = 10'd5;
        cycle();
        checks++; if (a_r0v !== 1'b1 || a_r0 !== 64'h0) begin errs++; $display("FAIL init_rd_a: got v=%b %h want v=1 0", a_r0v, a_r0); end
        checks++; if (a_rwv !== 1'b1 || a_rw !== 64'h0) begin errs++; $display("FAIL init_rw_a: got v=%b %h want v=1 0", a_rwv, a_rw); end
        checks++; if (b_r0v !== 1'b0) begin errs++; $display("FAIL lat2_early: got v=%b want 0", b_r0v); end
        idle();
        cycle();
        checks++; if (a_r0v !== 1'b0 || a_r0 !== 64'h0) begin errs++; $display("FAIL hold_a: got v=%b %h want v=0 0", a_r0v, a_r0); end
        checks++; if (b_r0v !== 1'b1 || b_r0 !== B_INIT) begin errs++; $display("FAIL init_rd_b: got v=%b %h want v=1 %h", b_r0v, b_r0, B_INIT); end
        checks++; if (b_rwv !== 1'b1 || b_rw !== B_INIT) begin errs++; $display("FAIL init_rw_b: got v=%b %h want v=1 %h", b_rwv, b_rw, B_INIT); end
    endtask

    task automatic test_mask();
        idle(); rw_ce = 1'b1; rw_we = 1'b1; rw_mask = 8'hFF; rw_addr = 10'h3A; rw_wd = 64'h1122334455667788;
        cycle();
        rw_mask = 8'h0F; rw_wd = 64'hAAAAAAAAAAAAAAAA;
        cycle();
        checks++; if (a_rw !== 64'h1122334455667788) begin errs++; $display("FAIL read_first_a: got %h want 1122334455667788", a_rw); end
        checks++; if (b_rwv !== 1'b1 || b_rw !== B_INIT) begin errs++; $display("FAIL read_first_b: got v=%b %h want v=1 %h", b_rwv, b_rw, B_INIT); end
        rw_mask = 8'h00; rw_wd = ONES; r0_ce = 1'b1; r0_addr = 10'h3A;
        cycle();
        checks++; if (a_rwv !== 1'b1 || a_rw !== MIX) begin errs++; $display("FAIL noop_wr_a: got v=%b %h want v=1 %h", a_rwv, a_rw, MIX); end
        checks++; if (a_r0 !== MIX) begin errs++; $display("FAIL mask_rd_a: got %h want %h", a_r0, MIX); end
        checks++; if (b_rw !== 64'h1122334455667788) begin errs++; $display("FAIL read_first2_b: got %h want 1122334455667788", b_rw); end
        idle();
        cycle();
        checks++; if (b_r0 !== MIX || b_rw !== MIX) begin errs++; $display("FAIL mask_b: got r0=%h rw=%h want %h", b_r0, b_rw, MIX); end
        cycle();
    endtask

    task automatic test_collision();
        idle(); r0_ce = 1'b1; r0_addr = 10'd7; rw_ce = 1'b1; rw_we = 1'b1; rw_mask = 8'hFF; rw_addr = 10'd7; rw_wd = ONES;
        cycle();
        checks++; if (a_r0 !== ONES) begin errs++; $display("FAIL coll_fwd_a: got %h want %h", a_r0, ONES); end
        checks++; if (a_rw !== 64'h0) begin errs++; $display("FAIL coll_rw_a: got %h want 0", a_rw); end
        idle();
        cycle();
        checks++; if (b_r0 !== B_INIT) begin errs++; $display("FAIL coll_nofwd_b: got %h want %h", b_r0, B_INIT); end
        checks++; if (b_rw !== B_INIT) begin errs++; $display("FAIL coll_rw_b: got %h want %h", b_rw, B_INIT); end
        r0_ce = 1'b1;
        cycle();
        checks++; if (a_r0 !== ONES) begin errs++; $display("FAIL coll_after_a: got %h want %h", a_r0, ONES); end
        idle();
        cycle();
        checks++; if (b_r0 !== ONES) begin errs++; $display("FAIL coll_after_b: got %h want %h", b_r0, ONES); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ea, eb;
        for (int k = 1; k <= 3; k++) begin
            idle(); rw_ce = 1'b1; rw_we = 1'b1; rw_mask = 8'hFF; rw_addr = 10'(k); rw_wd = 64'(16 * k);
            cycle();
        end
        idle();
        repeat (2) cycle();
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k < 3) begin r0_ce = 1'b1; r0_addr = 10'(k + 1); end
            cycle();
            ea = (k < 3) ? 64'(16 * (k + 1)) : 64'h30;
            eb = (k >= 1 && k <= 3) ? 64'(16 * k) : 64'h30;
            checks++; if (a_r0v !== (k < 3) || a_r0 !== ea) begin errs++; $display("FAIL pipe_a[%0d]: got v=%b %h want v=%b %h", k, a_r0v, a_r0, k < 3, ea); end
            checks++; if (b_r0v !== (k >= 1 && k <= 3) || (k > 0 && b_r0 !== eb)) begin errs++; $display("FAIL pipe_b[%0d]: got v=%b %h want v=%b %h", k, b_r0v, b_r0, k >= 1 && k <= 3, eb); end
        end
    endtask

    task automatic test_out_of_range();
        checks++; if (b_err !== 1'b0) begin errs++; $display("FAIL err_pre_b: got %b want 0", b_err); end
        idle(); rw_ce = 1'b1; rw_we = 1'b1; rw_mask = 8'hFF; rw_addr = 10'd1010; rw_wd = D5;
        cycle();
        checks++; if (a_rwv !== 1'b1 || a_rw !== 64'h0 || a_err !== 1'b0) begin errs++; $display("FAIL inrange_wr_a: got v=%b %h err=%b want v=1 0 err=0", a_rwv, a_rw, a_err); end
        idle();
        cycle();
        checks++; if (b_rwv !== 1'b1 || b_rw !== 64'h0) begin errs++; $display("FAIL oor_rw_b: got v=%b %h want v=1 0", b_rwv, b_rw); end
        checks++; if (b_err !== 1'b1) begin errs++; $display("FAIL oor_err_b: got %b want 1", b_err); end
        r0_ce = 1'b1; r0_addr = 10'd1010; rw_ce = 1'b1; rw_addr = 10'd999;
        cycle();
        checks++; if (a_r0 !== D5 || a_rw !== 64'h0) begin errs++; $display("FAIL inrange_rd_a: got r0=%h rw=%h want %h 0", a_r0, a_rw, D5); end
        idle();
        cycle();
        checks++; if (b_r0v !== 1'b1 || b_r0 !== 64'h0) begin errs++; $display("FAIL oor_rd_b: got v=%b %h want v=1 0", b_r0v, b_r0); end
        checks++; if (b_rw !== B_INIT) begin errs++; $display("FAIL last_word_b: got %h want %h", b_rw, B_INIT); end
        checks++; if (a_err !== 1'b0) begin errs++; $display("FAIL err_a: got %b want 0", a_err); end
    endtask

    task automatic test_reset_mid_init();
        int ta, tb, nv;
        idle();
        repeat (3) cycle();
        checks++; if (b_err !== 1'b1) begin errs++; $display("FAIL err_sticky_b: got %b want 1", b_err); end
        rw_ce = 1'b1; rw_we = 1'b1; rw_mask = 8'hFF; rw_addr = 10'd900; rw_wd = D9;
        cycle();
        idle();
        cycle();
        r0_ce = 1'b1; r0_addr = 10'd900;
        cycle();
        checks++; if (a_r0v !== 1'b1 || a_r0 !== D9) begin errs++; $display("FAIL pre_wr_a: got v=%b %h want v=1 %h", a_r0v, a_r0, D9); end
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (a_r0 !== 64'h0 || a_r0v !== 1'b0 || a_done !== 1'b0) begin errs++; $display("FAIL async_rst_a: got %h v=%b done=%b want 0", a_r0, a_r0v, a_done); end
        checks++; if (b_err !== 1'b0 || b_done !== 1'b0) begin errs++; $display("FAIL async_rst_b: got err=%b done=%b want 0", b_err, b_done); end
        cycle();
        checks++; if (b_r0v !== 1'b0) begin errs++; $display("FAIL inflight_b: got v=%b want 0", b_r0v); end
        rst_n = 1'b1;
        repeat (300) cycle();
        checks++; if (a_done !== 1'b0 || b_done !== 1'b0) begin errs++; $display("FAIL mid_init_done: got a=%b b=%b want 0", a_done, b_done); end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        wait_init(1'b0, ta, tb, nv);
        checks++; if (ta != 1025) begin errs++; $display("FAIL reinit_time_a: got %0d want 1025", ta); end
        checks++; if (tb != 1001) begin errs++; $display("FAIL reinit_time_b: got %0d want 1001", tb); end
        r0_ce = 1'b1; r0_addr = 10'd900;
        cycle();
        checks++; if (a_r0 !== 64'h0) begin errs++; $display("FAIL cleared_a: got %h want 0", a_r0); end
        idle();
        cycle();
        checks++; if (b_r0 !== B_INIT) begin errs++; $display("FAIL cleared_b: got %h want %h", b_r0, B_INIT); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_read();
        test_mask();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_init();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
